// File: rtl/data_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_bridge
// Brief    : M-stage data-port slave that decodes CPU accesses into a
//            byte-enabled data RAM and a countdown timer with an interrupt.
//            The optional write trace is enabled by BRIDGE_WRITE_TRACE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module data_bus_bridge #(
   parameter int          DM_WORDS   = 3072,
   parameter logic [31:0] TIMER_BASE = 32'h0000_7F00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m_data_addr,
   input  logic [31:0] m_data_wdata,
   input  logic [3:0]  m_data_byteen,
   input  logic [31:0] m_inst_addr,
   output logic [31:0] m_data_rdata,
   output logic        irq
);
   localparam int          c_AW       = $clog2(DM_WORDS);
   localparam logic [31:0] c_DM_BYTES = 32'(4 * DM_WORDS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CNT  = 2'd2,
      S_INT  = 2'd3
   } state_t;

   logic [31:0]     r_dm [DM_WORDS];
   logic [3:0]      r_ctrl;
   logic [31:0]     r_preset;
   logic [31:0]     r_count;
   logic            r_irq_flag;
   logic            r_irq;
   state_t          r_state;
   state_t          w_state_nxt;
   logic [31:0]     w_count_nxt;
   logic            w_en_clr;
   logic            w_flag_set;
   logic            w_flag_clr_fsm;
   logic            w_dm_hit;
   logic            w_tmr_hit;
   logic [31:0]     w_tmr_off;
   logic [1:0]      w_tmr_sel;
   logic [c_AW-1:0] w_dm_idx;
   logic [31:0]     w_dm_merged;
   logic            w_dm_we;
   logic            w_ctrl_we;
   logic            w_preset_we;
   logic            w_unused;

   assign w_dm_hit    = (m_data_addr < c_DM_BYTES);
   assign w_tmr_hit   = (m_data_addr >= TIMER_BASE) && (m_data_addr <= TIMER_BASE + 32'd11);
   assign w_tmr_off   = m_data_addr - TIMER_BASE;
   assign w_tmr_sel   = w_tmr_off[3:2];
   assign w_dm_idx    = m_data_addr[c_AW+1:2];
   assign w_dm_we     = w_dm_hit && (m_data_byteen != 4'b0000);
   // Timer registers only accept full-word stores; COUNT is never writable.
   assign w_ctrl_we   = w_tmr_hit && (m_data_byteen == 4'b1111) && (w_tmr_sel == 2'd0);
   assign w_preset_we = w_tmr_hit && (m_data_byteen == 4'b1111) && (w_tmr_sel == 2'd1);
   assign w_unused    = ^{m_inst_addr, w_tmr_off[31:4], w_tmr_off[1:0], m_data_addr[1:0]};

   always_comb begin
      w_dm_merged = r_dm[w_dm_idx];
      for (int i = 0; i < 4; i++) begin
         if (m_data_byteen[i]) w_dm_merged[8*i +: 8] = m_data_wdata[8*i +: 8];
      end
   end

   always_comb begin
      m_data_rdata = '0;
      if (w_dm_hit) begin
         m_data_rdata = r_dm[w_dm_idx];
      end else if (w_tmr_hit) begin
         case (w_tmr_sel)
            2'd0:    m_data_rdata = {28'd0, r_ctrl};
            2'd1:    m_data_rdata = r_preset;
            2'd2:    m_data_rdata = r_count;
            default: m_data_rdata = '0;
         endcase
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_count_nxt    = r_count;
      w_en_clr       = 1'b0;
      w_flag_set     = 1'b0;
      w_flag_clr_fsm = 1'b0;
      case (r_state)
         S_IDLE: if (r_ctrl[0]) w_state_nxt = S_LOAD;
         S_LOAD: begin
            w_count_nxt = r_preset;
            w_state_nxt = S_CNT;
         end
         S_CNT: begin
            if (!r_ctrl[0]) begin
               w_state_nxt = S_IDLE;
            end else if (r_count > 32'd1) begin
               w_count_nxt = r_count - 32'd1;
            end else begin
               w_count_nxt = '0;
               w_flag_set  = 1'b1;
               w_state_nxt = S_INT;
            end
         end
         S_INT: begin
            // Only MODE 01 reloads; 00 and 1x behave as one-shot.
            if (r_ctrl[2:1] == 2'b01) begin
               w_flag_clr_fsm = 1'b1;
               w_state_nxt    = S_LOAD;
            end else begin
               w_en_clr    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DM_WORDS; i++) r_dm[i] <= '0;
      end else if (w_dm_we) begin
         r_dm[w_dm_idx] <= w_dm_merged;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_ctrl     <= '0;
         r_preset   <= '0;
         r_count    <= '0;
         r_irq_flag <= 1'b0;
         r_irq      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         // A CPU store to CTRL overrides the FSM's EN clear in the same cycle.
         if (w_ctrl_we)     r_ctrl    <= m_data_wdata[3:0];
         else if (w_en_clr) r_ctrl[0] <= 1'b0;
         if (w_preset_we) r_preset <= m_data_wdata;
         if (w_ctrl_we || w_preset_we) r_irq_flag <= 1'b0;
         else if (w_flag_set)          r_irq_flag <= 1'b1;
         else if (w_flag_clr_fsm)      r_irq_flag <= 1'b0;
         r_irq <= r_ctrl[3] & r_irq_flag;
      end
   end

   assign irq = r_irq;

`ifdef BRIDGE_WRITE_TRACE_EN
   always_ff @(posedge clk) begin
      if (!reset && w_dm_we)
         $display("@%h: *%h <= %h", m_inst_addr, {m_data_addr[31:2], 2'b00}, w_dm_merged);
      else if (!reset && (w_ctrl_we || w_preset_we))
         $display("@%h: *%h <= %h", m_inst_addr, {m_data_addr[31:2], 2'b00}, m_data_wdata);
   end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_bus_bridge
// Brief    : Scoreboard bench for data_bus_bridge: DM lanes, decode, timer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_bus_bridge;
   localparam logic [31:0] c_TB = 32'h0000_7F00;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] m_data_addr = '0;
   logic [31:0] m_data_wdata = '0;
   logic [3:0]  m_data_byteen = '0;
   logic [31:0] m_inst_addr = '0;
   logic [31:0] m_data_rdata;
   logic        irq;

   int n_cmp = 0;
   int n_mis = 0;
   logic [31:0] exp_q [$];
   string       nm_q [$];
   logic [31:0] dm_model [int];

   data_bus_bridge dut (
      .clk          (clk),
      .reset        (reset),
      .m_data_addr  (m_data_addr),
      .m_data_wdata (m_data_wdata),
      .m_data_byteen(m_data_byteen),
      .m_inst_addr  (m_inst_addr),
      .m_data_rdata (m_data_rdata),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] dm_exp(input logic [31:0] a);
      int idx = int'(a[31:2]);
      return dm_model.exists(idx) ? dm_model[idx] : 32'd0;
   endfunction

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] w;
      @(negedge clk);
      m_data_addr   = a;
      m_data_wdata  = d;
      m_data_byteen = be;
      m_inst_addr   = 32'h0040_0000 + a;
      if (a < 32'h3000) begin
         w = dm_exp(a);
         for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
         dm_model[int'(a[31:2])] = w;
      end
      @(posedge clk);
      #1;
      m_data_byteen = '0;
   endtask

   task automatic issue_rd(input logic [31:0] a, input logic [31:0] e, input string nm);
      m_data_addr = a;
      exp_q.push_back(e);
      nm_q.push_back(nm);
      #1;
   endtask

   task automatic test_reset;
      logic [31:0] addrs [5] = '{32'h0, 32'h4, c_TB, c_TB + 4, c_TB + 8};
      logic [31:0] e;
      string nm;
      for (int i = 0; i < 5; i++) begin
         issue_rd(addrs[i], 32'd0, $sformatf("reset_rd_%h", addrs[i]));
         e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
         if (m_data_rdata !== e) begin
            n_mis++; $display("FAIL %s: got %h want %h", nm, m_data_rdata, e);
         end
      end
      n_cmp++;
      if (irq !== 1'b0) begin n_mis++; $display("FAIL reset_irq: got %b want 0", irq); end
   endtask

   task automatic test_dm;
      logic [31:0] addrs [6] = '{32'h4, 32'h6, 32'h7, 32'h0, 32'h2FFC, 32'h2FFF};
      logic [31:0] e;
      string nm;
      wr(32'h4, 32'h1234_5678, 4'b1111);
      wr(32'h6, 32'hAAAA_AAAA, 4'b0100);
      wr(32'h2FFC, 32'hCAFE_F00D, 4'b1111);
      wr(32'h2FFF, 32'h5555_5555, 4'b1000);
      for (int i = 0; i < 6; i++) begin
         issue_rd(addrs[i], dm_exp(addrs[i]), $sformatf("dm_rd_%h", addrs[i]));
         e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
         if (m_data_rdata !== e) begin
            n_mis++; $display("FAIL %s: got %h want %h", nm, m_data_rdata, e);
         end
      end
      issue_rd(32'h4, 32'h12AA_5678, "dm_lane_merge");
      e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
      if (m_data_rdata !== e) begin
         n_mis++; $display("FAIL %s: got %h want %h", nm, m_data_rdata, e);
      end
   endtask

   task automatic test_unmapped;
      logic [31:0] addrs [8] = '{32'h3000, 32'h5000, 32'h7EFC, c_TB + 12,
                                32'h1000, 32'h4, c_TB, c_TB + 4};
      logic [31:0] e;
      string nm;
      wr(32'h5000, 32'hDEAD_BEEF, 4'b1111);
      wr(32'h3000, 32'hDEAD_BEEF, 4'b1111);
      for (int i = 0; i < 8; i++) begin
         issue_rd(addrs[i], (i == 5) ? dm_exp(addrs[i]) : 32'd0, $sformatf("unmap_rd_%h", addrs[i]));
         e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
         if (m_data_rdata !== e) begin
            n_mis++; $display("FAIL %s: got %h want %h", nm, m_data_rdata, e);
         end
      end
   endtask

   task automatic test_oneshot;
      logic [31:0] e;
      wr(c_TB + 4, 32'd3, 4'b1111);
      wr(c_TB, 32'h9, 4'b1111);
      for (int v = 3; v >= 0; v--) exp_q.push_back(32'(v));
      tick(2);
      for (int k = 0; k < 4; k++) begin
         m_data_addr = c_TB + 8;
         #1;
         e = exp_q.pop_front(); n_cmp++;
         if (m_data_rdata !== e) begin
            n_mis++; $display("FAIL oneshot_count_%0d: got %h want %h", k, m_data_rdata, e);
         end
         n_cmp++;
         if (irq !== 1'b0) begin n_mis++; $display("FAIL oneshot_irq_low_%0d: got %b want 0", k, irq); end
         tick(1);
      end
      n_cmp++;
      if (irq !== 1'b1) begin n_mis++; $display("FAIL oneshot_irq_rise: got %b want 1", irq); end
      m_data_addr = c_TB;
      #1;
      n_cmp++;
      if (m_data_rdata !== 32'h8) begin
         n_mis++; $display("FAIL oneshot_ctrl_en_clr: got %h want 00000008", m_data_rdata);
      end
      tick(3);
      n_cmp++;
      if (irq !== 1'b1) begin n_mis++; $display("FAIL oneshot_irq_hold: got %b want 1", irq); end
      wr(c_TB, 32'h0, 4'b1111);
      tick(1);
      n_cmp++;
      if (irq !== 1'b0) begin n_mis++; $display("FAIL oneshot_irq_clear: got %b want 0", irq); end
   endtask

   task automatic test_autoreload;
      logic [31:0] cnt_exp [4] = '{32'd2, 32'd1, 32'd0, 32'd0};
      logic        irq_exp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [31:0] e;
      logic        ei;
      logic        irq_q [$];
      wr(c_TB + 4, 32'd2, 4'b1111);
      wr(c_TB, 32'hB, 4'b1111);
      tick(1);
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < 4; k++) begin
            exp_q.push_back(cnt_exp[k]);
            irq_q.push_back(irq_exp[k]);
         end
         for (int k = 0; k < 4; k++) begin
            tick(1);
            m_data_addr = c_TB + 8;
            #1;
            e = exp_q.pop_front(); ei = irq_q.pop_front(); n_cmp += 2;
            if (m_data_rdata !== e) begin
               n_mis++; $display("FAIL reload_count_p%0d_%0d: got %h want %h", p, k, m_data_rdata, e);
            end
            if (irq !== ei) begin
               n_mis++; $display("FAIL reload_irq_p%0d_%0d: got %b want %b", p, k, irq, ei);
            end
         end
      end
      wr(c_TB, 32'h0, 4'b1111);
      tick(2);
   endtask

   task automatic test_partial;
      logic [31:0] addrs [3] = '{c_TB, c_TB + 4, c_TB + 8};
      logic [31:0] exps  [3] = '{32'd0, 32'd2, 32'd2};
      logic [31:0] e;
      string nm;
      wr(c_TB + 4, 32'hFFFF_FFFF, 4'b0011);
      wr(c_TB, 32'hFFFF_FFFF, 4'b1110);
      wr(c_TB + 8, 32'h0000_0055, 4'b1111);
      tick(1);
      for (int i = 0; i < 3; i++) begin
         issue_rd(addrs[i], exps[i], $sformatf("partial_rd_%h", addrs[i]));
         e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
         if (m_data_rdata !== e) begin
            n_mis++; $display("FAIL %s: got %h want %h", nm, m_data_rdata, e);
         end
      end
   endtask

   task automatic test_reset_midcount;
      logic [31:0] addrs [4] = '{c_TB, c_TB + 4, c_TB + 8, 32'h4};
      logic [31:0] e;
      string nm;
      wr(c_TB + 4, 32'd6, 4'b1111);
      wr(c_TB, 32'h1, 4'b1111);
      tick(3);
      m_data_addr = c_TB + 8;
      #1;
      n_cmp++;
      if (m_data_rdata !== 32'd5) begin
         n_mis++; $display("FAIL midcount_pre: got %h want 00000005", m_data_rdata);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      dm_model.delete();
      for (int i = 0; i < 4; i++) begin
         issue_rd(addrs[i], 32'd0, $sformatf("midreset_rd_%h", addrs[i]));
         e = exp_q.pop_front(); nm = nm_q.pop_front(); n_cmp++;
         if (m_data_rdata !== e) begin
            n_mis++; $display("FAIL %s: got %h want %h", nm, m_data_rdata, e);
         end
      end
      n_cmp++;
      if (irq !== 1'b0) begin n_mis++; $display("FAIL midreset_irq: got %b want 0", irq); end
      tick(3);
      m_data_addr = c_TB + 8;
      #1;
      n_cmp++;
      if (m_data_rdata !== 32'd0) begin
         n_mis++; $display("FAIL midreset_idle_count: got %h want 00000000", m_data_rdata);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      test_reset();
      test_dm();
      test_unmapped();
      test_oneshot();
      test_autoreload();
      test_partial();
      test_reset_midcount();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
`default_nettype wire
